// File: rtl/fetch_stage_pkg.sv
// ============================================================================
// fetch_stage_pkg : shared encodings for the IF stage (NOP, reset PC, FSM)
// Rev 1.0
// ============================================================================
`default_nettype none

package fetch_stage_pkg;

    localparam logic [31:0] NOP_ENCODING     = 32'h0000_0000;  // sll $0,$0,0
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_KILL  = 2'd2,
        S_HOLD  = 2'd3
    } fetch_state_e;

    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_stage_if_id_reg.sv
// ============================================================================
// if_id_reg : IF/ID pipeline register with hold (stall) and bubble (flush)
// Rev 1.0
// ============================================================================
`default_nettype none

module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_ENCODING
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hold,
    input  logic        flush,
    input  logic        load,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_pc_plus4,
    output logic [31:0] instr,
    output logic [31:0] pc_plus4,
    output logic        valid
);

    logic [31:0] r_instr;
    logic [31:0] r_pc_plus4;
    logic        r_valid;

    // A bubble keeps pc_plus4 so a stalled-then-flushed slot never shows a stale zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr    <= NOP_INSTR;
            r_pc_plus4 <= 32'd0;
            r_valid    <= 1'b0;
        end else if (!hold) begin
            if (load && !flush) begin
                r_instr    <= load_instr;
                r_pc_plus4 <= load_pc_plus4;
                r_valid    <= 1'b1;
            end else begin
                r_instr    <= NOP_INSTR;
                r_valid    <= 1'b0;
            end
        end
    end

    assign instr    = r_instr;
    assign pc_plus4 = r_pc_plus4;
    assign valid    = r_valid;

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// fetch_stage : MIPS IF stage - PC, single-outstanding imem fetch, skid buffer
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = NOP_ENCODING
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_if,
    input  logic        stall_id,
    input  logic        branch_taken_id,
    input  logic [31:0] branch_target_id,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_id,
    output logic [31:0] pc_plus4_id,
    output logic        valid_id
);

    fetch_state_e r_state, w_state_nxt;
    logic [31:0]  r_pc, w_pc_nxt;
    logic [31:0]  r_outst_pc, w_outst_pc_nxt;
    logic [31:0]  r_buf, w_buf_nxt;
    logic         w_redirect;
    logic         w_req;
    logic         w_load;
    logic [31:0]  w_load_instr;

    // A branch held in ID by a stall has not been resolved yet
    assign w_redirect = branch_taken_id & ~stall_id;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_FETCH;
            r_pc       <= RESET_PC;
            r_outst_pc <= RESET_PC;
            r_buf      <= NOP_INSTR;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_outst_pc <= w_outst_pc_nxt;
            r_buf      <= w_buf_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_outst_pc_nxt = r_outst_pc;
        w_buf_nxt      = r_buf;
        w_req          = 1'b0;
        w_load         = 1'b0;
        w_load_instr   = imem_rdata;

        case (r_state)
            S_FETCH: begin
                w_req = ~stall_if & ~w_redirect;
                if (w_req && imem_gnt) begin
                    w_state_nxt    = S_WAIT;
                    w_outst_pc_nxt = r_pc;
                    w_pc_nxt       = pc_inc(r_pc);
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (stall_id) begin
                        w_buf_nxt   = imem_rdata;
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_load      = ~w_redirect;
                        w_state_nxt = S_FETCH;
                    end
                end else if (w_redirect) begin
                    w_state_nxt = S_KILL;
                end
            end
            S_KILL: begin
                if (imem_rvalid) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_HOLD: begin
                if (!stall_id) begin
                    w_load       = ~w_redirect;
                    w_load_instr = r_buf;
                    w_state_nxt  = S_FETCH;
                end
            end
            default: w_state_nxt = S_FETCH;
        endcase

        // Redirect wins over any sequential PC update (FETCH never grants on redirect)
        if (w_redirect) begin
            w_pc_nxt = branch_target_id;
        end
    end

    assign imem_req  = w_req & rst_n;
    assign imem_addr = r_pc;

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk           (clk),
        .rst_n         (rst_n),
        .hold          (stall_id),
        .flush         (w_redirect),
        .load          (w_load),
        .load_instr    (w_load_instr),
        .load_pc_plus4 (pc_inc(r_outst_pc)),
        .instr         (instr_id),
        .pc_plus4      (pc_plus4_id),
        .valid         (valid_id)
    );

endmodule

`default_nettype wire
